// File: rtl/elastic_arbiter_multiplexer_if.sv
// Handshake bundle for the elastic arbiter mux: N upstream channels in, one buffered stream out.
interface elastic_arbiter_multiplexer_if #(
  parameter int DATA_WIDTH           = 32,
  parameter int INPUT_NUM            = 4,
  parameter int INPUT_NUM_BIT_LENGTH = 2
);
  logic [INPUT_NUM-1:0][DATA_WIDTH-1:0] data_input;
  logic [INPUT_NUM-1:0]                 valid_input;
  logic [INPUT_NUM-1:0]                 stop_input;
  logic [DATA_WIDTH-1:0]                data_output;
  logic                                 valid_output;
  logic                                 stop_output;
  logic [INPUT_NUM_BIT_LENGTH-1:0]      output_index;
  logic [INPUT_NUM_BIT_LENGTH-1:0]      input_data_index;
  logic                                 arbitration_mode;

  modport slave (
    input  data_input, valid_input, stop_output, input_data_index, arbitration_mode,
    output stop_input, data_output, valid_output, output_index
  );

  modport master (
    output data_input, valid_input, stop_output, input_data_index, arbitration_mode,
    input  stop_input, data_output, valid_output, output_index
  );
endinterface

// File: rtl/elastic_arbiter_multiplexer.sv
// N-input elastic mux: static or round-robin grant feeding a registered FIFO, so
// upstream stop never depends combinationally on downstream stop.
module elastic_arbiter_lane #(
  parameter int IW   = 2,
  parameter int LANE = 0
) (
  input  logic [IW-1:0] gnt_i,
  input  logic          gnt_vld_i,
  input  logic          full_i,
  output logic          stop_o
);
  assign stop_o = !(gnt_vld_i && (gnt_i == IW'(LANE)) && !full_i);
endmodule

module elastic_arbiter_multiplexer #(
  parameter int DATA_WIDTH           = 32,
  parameter int INPUT_NUM            = 4,
  parameter int INPUT_NUM_BIT_LENGTH = 2,
  parameter int BUFFER_DEPTH         = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  elastic_arbiter_multiplexer_if.slave  bus
);
  localparam int IW = INPUT_NUM_BIT_LENGTH;
  localparam int PW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int CW = $clog2(BUFFER_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(BUFFER_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(BUFFER_DEPTH - 1);
  localparam logic [IW:0]   NUM_C    = (IW+1)'(INPUT_NUM);
  localparam logic [IW-1:0] LG_RST   = IW'(INPUT_NUM - 1);

  typedef struct packed {
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t                mem_q [BUFFER_DEPTH];
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [IW-1:0]         last_grant_q, last_grant_d;
  logic [IW-1:0]         rr_gnt, gnt;
  logic [IW:0]           cand;
  logic                  rr_vld, gnt_vld, full, push, pop, sel_vld;
  logic [DATA_WIDTH-1:0] sel_data;

  // Scan from farthest to nearest so the candidate right after last_grant wins.
  always_comb begin
    rr_gnt = '0;
    rr_vld = 1'b0;
    cand   = '0;
    for (int k = INPUT_NUM; k >= 1; k--) begin
      cand = {1'b0, last_grant_q} + (IW+1)'(k);
      if (cand >= NUM_C) cand = cand - NUM_C;
      if (bus.valid_input[cand[IW-1:0]]) begin
        rr_gnt = cand[IW-1:0];
        rr_vld = 1'b1;
      end
    end
  end

  assign gnt     = bus.arbitration_mode ? rr_gnt : bus.input_data_index;
  assign gnt_vld = bus.arbitration_mode ? rr_vld : ({1'b0, bus.input_data_index} < NUM_C);

  always_comb begin
    sel_vld  = 1'b0;
    sel_data = '0;
    for (int i = 0; i < INPUT_NUM; i++) begin
      if (gnt == IW'(i)) begin
        sel_vld  = bus.valid_input[i];
        sel_data = bus.data_input[i];
      end
    end
  end

  assign full = (count_q == DEPTH_C);
  assign push = gnt_vld && sel_vld && !full && !reset;
  assign pop  = bus.valid_output && !bus.stop_output;

  for (genvar i = 0; i < INPUT_NUM; i++) begin : g_lane
    elastic_arbiter_lane #(.IW(IW), .LANE(i)) u_lane (
      .gnt_i     (gnt),
      .gnt_vld_i (gnt_vld),
      .full_i    (full),
      .stop_o    (bus.stop_input[i])
    );
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (bus.arbitration_mode) last_grant_d = gnt;
    end
    if (pop) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      last_grant_q <= LG_RST;
      for (int i = 0; i < BUFFER_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      if (push) mem_q[wr_ptr_q] <= '{idx: gnt, data: sel_data};
    end
  end

  assign bus.valid_output = (count_q != '0);
  assign bus.data_output  = mem_q[rd_ptr_q].data;
  assign bus.output_index = mem_q[rd_ptr_q].idx;
endmodule
